// File: rtl/multi_pattern_comparator_if.sv
// Stream, pattern-programming and result signals of the multi-pattern comparator.
// The master drives the stream and the patterns; the slave (the comparator) returns the results.
interface multi_pattern_comparator_if #(
  parameter int DATA_BYTES    = 4,
  parameter int PATTERN_BYTES = 4,
  parameter int NUM_PATTERNS  = 2,
  parameter int CNT_W         = 8
);
  logic                                    clear;
  logic                                    data_valid;
  logic [8*DATA_BYTES-1:0]                 data_in;
  logic [8*PATTERN_BYTES*NUM_PATTERNS-1:0] pattern_in;
  logic [NUM_PATTERNS-1:0]                 pattern_en;
  logic [8*DATA_BYTES-1:0]                 data_out;
  logic                                    data_out_valid;
  logic                                    match;
  logic [NUM_PATTERNS-1:0]                 match_vec;
  logic [CNT_W-1:0]                        match_count;

  modport master (
    output clear, data_valid, data_in, pattern_in, pattern_en,
    input  data_out, data_out_valid, match, match_vec, match_count
  );

  modport slave (
    input  clear, data_valid, data_in, pattern_in, pattern_en,
    output data_out, data_out_valid, match, match_vec, match_count
  );
endinterface

// File: rtl/multi_pattern_comparator.sv
// Searches a big-endian byte stream for NUM_PATTERNS patterns at every byte alignment,
// with sticky hit flags, a saturating hit counter and a fixed-latency data forward path.
module multi_pattern_comparator #(
  parameter int DATA_BYTES    = 4,
  parameter int PATTERN_BYTES = 4,
  parameter int NUM_PATTERNS  = 2,
  parameter int DELAY         = 3,
  parameter int CNT_W         = 8
) (
  input logic                     clk,
  input logic                     n_rst,
  multi_pattern_comparator_if.slave bus
);
  localparam int HIST_BYTES = PATTERN_BYTES + DATA_BYTES - 1;
  localparam int HIST_W     = 8 * HIST_BYTES;
  localparam int WORD_W     = 8 * DATA_BYTES;
  localparam int PAT_W      = 8 * PATTERN_BYTES;
  localparam int FILL_W     = $clog2(HIST_BYTES + 1);

  // Newest accepted byte sits in the LSBs; a window is only trusted once all its bytes arrived.
  function automatic logic window_hit(input logic [HIST_W-1:0] hist,
                                      input logic [FILL_W-1:0] fill,
                                      input logic [PAT_W-1:0]  pat);
    logic hit_v;
    hit_v = 1'b0;
    for (int o = 0; o < DATA_BYTES; o++) begin
      if ((int'(fill) >= (DATA_BYTES - o + PATTERN_BYTES - 1)) &&
          (hist[8*(DATA_BYTES-1-o) +: PAT_W] == pat)) begin
        hit_v = 1'b1;
      end else begin
        hit_v = hit_v;
      end
    end
    return hit_v;
  endfunction

  logic [HIST_W-1:0]        hist_r;
  logic [FILL_W-1:0]        fill_r;
  logic                     word_new_r;
  logic [NUM_PATTERNS-1:0]  match_vec_r;
  logic                     match_r;
  logic [CNT_W-1:0]         match_count_r;
  logic [WORD_W:0]          pipe_r [DELAY];
  logic [WORD_W:0]          out_r;

  logic [HIST_W+WORD_W-1:0] shifted_s;
  logic [FILL_W-1:0]        fill_next_s;
  int                       fill_sum_s;
  logic [NUM_PATTERNS-1:0]  hit_s;
  logic [NUM_PATTERNS-1:0]  match_vec_next_s;

  // Next history and saturating byte-fill count for an accepted word.
  always_comb begin
    shifted_s  = {hist_r, bus.data_in};
    fill_sum_s = int'(fill_r) + DATA_BYTES;
    if (fill_sum_s > HIST_BYTES) begin
      fill_next_s = FILL_W'(HIST_BYTES);
    end else begin
      fill_next_s = FILL_W'(fill_sum_s);
    end
  end

  // Hits are evaluated only for the word accepted on the previous edge.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      hit_s[i] = window_hit(hist_r, fill_r, bus.pattern_in[i*PAT_W +: PAT_W]) &
                 bus.pattern_en[i] & word_new_r;
    end
    match_vec_next_s = match_vec_r | hit_s;
  end

  // Search state, sticky flags and counter; clear wins over a same-edge word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist_r        <= '0;
      fill_r        <= '0;
      word_new_r    <= 1'b0;
      match_vec_r   <= '0;
      match_r       <= 1'b0;
      match_count_r <= '0;
    end else if (bus.clear) begin
      hist_r        <= '0;
      fill_r        <= '0;
      word_new_r    <= 1'b0;
      match_vec_r   <= '0;
      match_r       <= 1'b0;
      match_count_r <= '0;
    end else begin
      if (bus.data_valid) begin
        hist_r <= shifted_s[HIST_W-1:0];
        fill_r <= fill_next_s;
      end
      word_new_r  <= bus.data_valid;
      match_vec_r <= match_vec_next_s;
      match_r     <= |match_vec_next_s;
      if ((|hit_s) && (match_count_r != {CNT_W{1'b1}})) begin
        match_count_r <= match_count_r + CNT_W'(1);
      end
    end
  end

  // Forward path: DELAY stages plus an output register, so a word trails its match result by DELAY-1 edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DELAY; i++) pipe_r[i] <= '0;
      out_r <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < DELAY; i++) pipe_r[i] <= '0;
      out_r <= '0;
    end else begin
      pipe_r[0] <= bus.data_valid ? {1'b1, bus.data_in} : {1'b0, {WORD_W{1'b0}}};
      for (int i = 1; i < DELAY; i++) pipe_r[i] <= pipe_r[i-1];
      out_r <= pipe_r[DELAY-1];
    end
  end

  assign bus.data_out       = out_r[WORD_W-1:0];
  assign bus.data_out_valid = out_r[WORD_W];
  assign bus.match          = match_r;
  assign bus.match_vec      = match_vec_r;
  assign bus.match_count    = match_count_r;
endmodule

// File: tb/tb_multi_pattern_comparator.sv
// Directed bench: flag/counter checks inline, forwarded words checked by a queue-based monitor.
module tb_multi_pattern_comparator;
  localparam int DELAY = 3;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  logic clk;
  logic n_rst;
  int   edge_n;
  int   compared;
  int   failed;
  bit   running;
  exp_t sb[$];

  multi_pattern_comparator_if #(.DATA_BYTES(4), .PATTERN_BYTES(4), .NUM_PATTERNS(2), .CNT_W(8)) bus ();

  multi_pattern_comparator #(
    .DATA_BYTES(4), .PATTERN_BYTES(4), .NUM_PATTERNS(2), .DELAY(DELAY), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // One edge of stimulus; valid words are queued with the edge after which they must emerge.
  task automatic drive(input logic v, input logic [31:0] d, input logic clr);
    exp_t e;
    bus.data_valid = v;
    bus.data_in    = d;
    bus.clear      = clr;
    if (clr) begin
      while (sb.size() > 0 && sb[$].edge_no >= edge_n + 1) void'(sb.pop_back());
    end else if (v) begin
      e.data    = d;
      e.edge_no = edge_n + 1 + DELAY;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, 32'h0000_0000, 1'b1);
  endtask

  // Scoreboard monitor: every valid output word must match the oldest queued word at its due edge.
  always @(negedge clk) begin
    exp_t e;
    if (running) begin
      if (bus.data_out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL data_out unexpected: got %h expected no valid word", bus.data_out);
        end else begin
          e = sb.pop_front();
          check("data_out word", bus.data_out, e.data);
          check("data_out edge", 32'(edge_n), 32'(e.edge_no));
        end
      end else begin
        check("data_out bubble", bus.data_out, 32'h0000_0000);
      end
    end
  end

  initial begin
    edge_n         = 0;
    compared       = 0;
    failed         = 0;
    running        = 1'b0;
    n_rst          = 1'b0;
    bus.clear      = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = 32'h0000_0000;
    bus.pattern_in = {32'h0000_0000, 32'hC0A8_0101};
    bus.pattern_en = 2'b01;

    // 1. reset and aligned hit
    tick();
    tick();
    check("rst match", 32'(bus.match), 32'h0);
    check("rst match_vec", 32'(bus.match_vec), 32'h0);
    check("rst match_count", 32'(bus.match_count), 32'h0);
    check("rst data_out_valid", 32'(bus.data_out_valid), 32'h0);
    check("rst data_out", bus.data_out, 32'h0);
    n_rst   = 1'b1;
    running = 1'b1;
    tick();
    drive(1'b1, 32'hC0A8_0101, 1'b0);
    check("t1 match before k+1", 32'(bus.match), 32'h0);
    idle();
    check("t1 match_vec", 32'(bus.match_vec), 32'h1);
    check("t1 match_count", 32'(bus.match_count), 32'h1);
    check("t1 match", 32'(bus.match), 32'h1);
    repeat (4) idle();

    // 2. straddle at offset 0
    do_clear();
    drive(1'b1, 32'h00C0_A801, 1'b0);
    idle();
    check("t2 match after first", 32'(bus.match), 32'h0);
    drive(1'b1, 32'h0100_0000, 1'b0);
    idle();
    check("t2 match_vec", 32'(bus.match_vec), 32'h1);
    check("t2 match_count", 32'(bus.match_count), 32'h1);
    repeat (4) idle();

    // 3. straddle at offset 2 across a 5-cycle gap
    do_clear();
    drive(1'b1, 32'h0000_00C0, 1'b0);
    repeat (5) idle();
    check("t3 match during gap", 32'(bus.match), 32'h0);
    drive(1'b1, 32'hA801_0100, 1'b0);
    idle();
    check("t3 match_vec", 32'(bus.match_vec), 32'h1);
    check("t3 match_count", 32'(bus.match_count), 32'h1);
    repeat (4) idle();

    // 4. all-zero pattern must not hit zeroed history
    do_clear();
    bus.pattern_in = {32'h0000_0000, 32'hC0A8_0101};
    bus.pattern_en = 2'b10;
    drive(1'b1, 32'h0000_AAAA, 1'b0);
    idle();
    check("t4 match partial fill", 32'(bus.match), 32'h0);
    check("t4 count partial fill", 32'(bus.match_count), 32'h0);
    drive(1'b1, 32'h0000_0000, 1'b0);
    idle();
    check("t4 match_vec", 32'(bus.match_vec), 32'h2);
    check("t4 match_count", 32'(bus.match_count), 32'h1);
    repeat (4) idle();

    // 5. enables and equal patterns
    do_clear();
    bus.pattern_in = {32'hC0A8_0101, 32'hC0A8_0101};
    bus.pattern_en = 2'b10;
    drive(1'b1, 32'hC0A8_0101, 1'b0);
    drive(1'b1, 32'hC0A8_0101, 1'b0);
    idle();
    check("t5 match_vec", 32'(bus.match_vec), 32'h2);
    check("t5 match_count", 32'(bus.match_count), 32'h2);
    bus.pattern_en = 2'b00;
    drive(1'b1, 32'hC0A8_0101, 1'b0);
    idle();
    check("t5 match_vec disabled", 32'(bus.match_vec), 32'h2);
    check("t5 count disabled", 32'(bus.match_count), 32'h2);
    repeat (4) idle();

    // 6. saturation, then clear with a same-edge valid word
    do_clear();
    bus.pattern_en = 2'b01;
    repeat (300) drive(1'b1, 32'hC0A8_0101, 1'b0);
    idle();
    check("t6 count saturated", 32'(bus.match_count), 32'hFF);
    check("t6 match_vec", 32'(bus.match_vec), 32'h1);
    drive(1'b1, 32'hC0A8_0101, 1'b1);
    bus.clear = 1'b0;
    check("t6 clear match", 32'(bus.match), 32'h0);
    check("t6 clear match_vec", 32'(bus.match_vec), 32'h0);
    check("t6 clear match_count", 32'(bus.match_count), 32'h0);
    check("t6 clear data_out_valid", 32'(bus.data_out_valid), 32'h0);
    repeat (DELAY + 3) idle();
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
